// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that sequences N_REQ requesters onto one shared WIDTH-bit register.
// Optional burst-lock grants are enabled by defining ARB_LOCK_EN.
module shared_reg_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid
);

    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LCNT_W = $clog2(LOCK_MAX + 1);

    if (N_REQ < 2 || LOCK_MAX < 1) begin : g_bad_param
        $error("shared_reg_arbiter: needs N_REQ >= 2 and LOCK_MAX >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   cur_q, cur_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [WIDTH-1:0]   q_d;
    logic               q_valid_d;
    logic [PTR_W-1:0]   win;
    logic               win_found;
    logic [PTR_W-1:0]   cand;
    logic [WIDTH-1:0]   sel_data;
    logic               hold;
`ifdef ARB_LOCK_EN
    logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
`endif

    // Round-robin scan starting just after the last serviced requester, explicit wrap.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = ptr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (cand == PTR_W'(N_REQ - 1)) ? '0 : cand + PTR_W'(1);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = wdata[int'(cur_q)*WIDTH +: WIDTH];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        gnt_d     = gnt;
        q_d       = q;
        q_valid_d = 1'b0;
        hold      = 1'b0;
`ifdef ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    state_d = GRANT;
                    cur_d   = win;
                    gnt_d   = N_REQ'(1) << win;
`ifdef ARB_LOCK_EN
                    lock_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (req[cur_q]) begin
                    q_d       = sel_data;
                    q_valid_d = 1'b1;
                end
`ifdef ARB_LOCK_EN
                // Burst continues while locked; the final (LOCK_MAX-th) write takes the normal exit.
                if (req[cur_q] && lock[cur_q] && (lock_cnt_q < LCNT_W'(LOCK_MAX - 1))) begin
                    hold       = 1'b1;
                    lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                end
`endif
                if (!hold) begin
                    ptr_d   = cur_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            cur_q   <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            gnt     <= gnt_d;
            q       <= q_d;
            q_valid <= q_valid_d;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

endmodule
